// File: rtl/mb_mcs_io_top.sv
// Papilio board I/O controller: UART (8N1) command engine driving gpio_o, reading gpio_i, plus LED.
// Define MB_MCS_HEARTBEAT_EN to build the free-running heartbeat counter on led; otherwise led = gpio_o[0].
module mb_mcs_io_top #(
  parameter int CLK_HZ       = 32000000,
  parameter int BAUD         = 115200,
  parameter int LED_DIV_BITS = 24
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       rxd,
  output logic       txd,
  output logic       led,
  output logic [7:0] gpio_o,
  input  logic [7:0] gpio_i
);

  localparam int BIT_CYC  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF_CYC = (BIT_CYC + 1) / 2;
  localparam int CW       = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
  typedef enum logic [1:0] {CMD_IDLE, CMD_ARG, CMD_RESP} cmd_state_e;

  // Synchronizers; the rxd chain resets to the idle line level.
  logic       rxd_m_q, rxd_s_q, rxd_p_q;
  logic [7:0] gpio_m_q, gpio_s_q;

  rx_state_e  rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_done_q, rx_done_d;

  cmd_state_e cmd_state_q, cmd_state_d;
  logic       resp_push;
  logic [7:0] resp_byte;
  logic       gpio_we;
  logic [7:0] gpio_q, gpio_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] pend_q, pend_d;

  logic       tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bitn_q, tx_bitn_d;
  logic [8:0] tx_shift_q, tx_shift_d;
  logic       txd_q, txd_d;
  logic       tx_load;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rxd_m_q     <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_p_q     <= 1'b1;
      gpio_m_q    <= 8'h00;
      gpio_s_q    <= 8'h00;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_done_q   <= 1'b0;
      cmd_state_q <= CMD_IDLE;
      gpio_q      <= 8'h00;
      pend_vld_q  <= 1'b0;
      pend_q      <= 8'h00;
      tx_busy_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bitn_q   <= 4'd0;
      tx_shift_q  <= 9'h1FF;
      txd_q       <= 1'b1;
    end else begin
      rxd_m_q     <= rxd;
      rxd_s_q     <= rxd_m_q;
      rxd_p_q     <= rxd_s_q;
      gpio_m_q    <= gpio_i;
      gpio_s_q    <= gpio_m_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_done_q   <= rx_done_d;
      cmd_state_q <= cmd_state_d;
      gpio_q      <= gpio_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      tx_busy_q   <= tx_busy_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bitn_q   <= tx_bitn_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
    end
  end

  // Receiver: a framing error parks in RX_WAIT until the line has been high for a full bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_p_q && !rxd_s_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rxd_s_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rxd_s_q) begin
            rx_done_d  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (!rxd_s_q) begin
          rx_cnt_d = '0;
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Command FSM: RESP marks the cycle in which a response has just been queued.
  always_comb begin
    cmd_state_d = cmd_state_q;
    case (cmd_state_q)
      CMD_ARG:  if (rx_done_q) cmd_state_d = CMD_RESP;
      default: begin
        cmd_state_d = CMD_IDLE;
        if (rx_done_q) cmd_state_d = (rx_shift_q == 8'h57) ? CMD_ARG : CMD_RESP;
      end
    endcase
  end

  always_comb begin
    resp_push = 1'b0;
    resp_byte = 8'h3F;
    gpio_we   = 1'b0;
    if (rx_done_q) begin
      if (cmd_state_q == CMD_ARG) begin
        gpio_we   = 1'b1;
        resp_push = 1'b1;
        resp_byte = 8'h4B;
      end else begin
        resp_push = (rx_shift_q != 8'h57);
        case (rx_shift_q)
          8'h52:   resp_byte = gpio_s_q;
          8'h53:   resp_byte = 8'hA5;
          default: resp_byte = 8'h3F;
        endcase
      end
    end
  end

  // Pending response: a push in the same cycle as a load keeps the new byte pending.
  always_comb begin
    gpio_d     = gpio_we ? rx_shift_q : gpio_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (tx_load) pend_vld_d = 1'b0;
    if (resp_push) begin
      pend_vld_d = 1'b1;
      pend_d     = resp_byte;
    end
  end

  assign tx_load = !tx_busy_q && pend_vld_q;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bitn_d  = tx_bitn_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    if (!tx_busy_q) begin
      if (pend_vld_q) begin
        tx_busy_d  = 1'b1;
        txd_d      = 1'b0;
        tx_shift_d = {1'b1, pend_q};
        tx_cnt_d   = '0;
        tx_bitn_d  = 4'd0;
      end
    end else if (tx_cnt_q == BIT_LAST) begin
      tx_cnt_d = '0;
      if (tx_bitn_q == 4'd9) begin
        tx_busy_d = 1'b0;
      end else begin
        txd_d      = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bitn_d  = tx_bitn_q + 4'd1;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  assign txd    = txd_q;
  assign gpio_o = gpio_q;

`ifdef MB_MCS_HEARTBEAT_EN
  logic [LED_DIV_BITS-1:0] hb_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) hb_q <= '0;
    else         hb_q <= hb_q + 1'b1;
  end

  assign led = hb_q[LED_DIV_BITS-1];
`else
  assign led = (LED_DIV_BITS > 0) & gpio_q[0];
`endif

endmodule

// File: tb/tb_mb_mcs_io_top.sv
// Bench for mb_mcs_io_top: UART-level model of the command protocol, frame decoder on txd,
// per-cycle checks of gpio_o/led/txd timing, plus literal spot checks.
module tb_mb_mcs_io_top;
  localparam int BIT     = 278;
  localparam int LDB     = 4;
  localparam int RX2TX   = 2646;  // rxd start-bit drive -> txd falls (idle TX)
  localparam int RX2GPIO = 2645;  // rxd start-bit drive of argument byte -> gpio_o updated
  localparam int FRAME   = 2781;  // start-to-start spacing of back-to-back TX frames

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] gpio_i = 8'h96;
  logic       txd, led;
  logic [7:0] gpio_o;

  mb_mcs_io_top #(.CLK_HZ(32000000), .BAUD(115200), .LED_DIV_BITS(LDB)) dut (
    .clk(clk), .resetb(resetb), .rxd(rxd), .txd(txd), .led(led), .gpio_o(gpio_o), .gpio_i(gpio_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] b;
    int         t;
    bit         exact;
  } resp_t;
  resp_t expq[$];

  logic [7:0] gpio_cur = 8'h00;
  logic [7:0] gpio_nxt = 8'h00;
  int         gpio_at = -1;
  bit         arg_pend = 1'b0;
  int         rel_cyc = 0;
  int         last_start = -100000;

  bit         mon_busy = 1'b0;
  int         mon_t = 0;
  int         mon_off = 0;
  int         mon_k = 0;
  logic [7:0] mon_b = 8'h00;
  logic [7:0] last_tx_byte = 8'h00;
  logic [7:0] prev_tx_byte = 8'h00;
  int         last_tx_start = 0;
  int         n_tx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol model: what each received byte must produce, and when.
  task automatic model_byte(input logic [7:0] b, input int t0);
    resp_t r;
    bit    push;
    push = 1'b1;
    r.b  = 8'h3F;
    if (arg_pend) begin
      gpio_nxt = b;
      gpio_at  = t0 + RX2GPIO;
      r.b      = 8'h4B;
      arg_pend = 1'b0;
    end else if (b == 8'h57) begin
      arg_pend = 1'b1;
      push     = 1'b0;
    end else if (b == 8'h52) begin
      r.b = gpio_i;
    end else if (b == 8'h53) begin
      r.b = 8'hA5;
    end
    if (push) begin
      r.t     = t0 + RX2TX;
      r.exact = 1'b1;
      if (last_start + FRAME > r.t) begin
        r.t     = last_start + FRAME;
        r.exact = 1'b0;
      end
      last_start = r.t;
      expq.push_back(r);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int t0);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(posedge clk);
    #1;
    t0 = cyc;
    model_byte(b, t0);
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, and txd frame decoding.
  always @(negedge clk) begin
    if (!resetb) begin
      mon_busy = 1'b0;
      chk("txd_in_reset", txd, 1);
      chk("gpio_in_reset", gpio_o, 8'h00);
      chk("led_in_reset", led, 0);
    end else begin
      if (gpio_at >= 0 && cyc >= gpio_at) begin
        gpio_cur = gpio_nxt;
        gpio_at  = -1;
      end
      chk("gpio_o", gpio_o, gpio_cur);
`ifdef MB_MCS_HEARTBEAT_EN
      chk("led_heartbeat", led, ((cyc - rel_cyc) >> (LDB - 1)) & 1);
`else
      chk("led_gpio0", led, gpio_cur[0]);
`endif
      if (!mon_busy) begin
        if (txd === 1'b0) begin
          mon_busy      = 1'b1;
          mon_t         = cyc;
          last_tx_start = cyc;
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected: txd fell at cycle %0d, expected no response", cyc);
          end else if (expq[0].exact) begin
            chk("tx_start_cycle", cyc, expq[0].t);
          end else begin
            chk("tx_start_window", (cyc >= expq[0].t - 1) && (cyc <= expq[0].t + 1), 1);
          end
        end
      end else begin
        mon_off = cyc - mon_t;
        if (mon_off >= BIT / 2 && (mon_off - BIT / 2) % BIT == 0) begin
          mon_k = (mon_off - BIT / 2) / BIT;
          if (mon_k == 0) begin
            chk("tx_start_bit", txd, 0);
          end else if (mon_k <= 8) begin
            mon_b[mon_k-1] = txd;
          end else begin
            chk("tx_stop_bit", txd, 1);
            if (expq.size() != 0) begin
              chk("tx_byte", mon_b, expq[0].b);
              void'(expq.pop_front());
            end
            prev_tx_byte = last_tx_byte;
            last_tx_byte = mon_b;
            n_tx++;
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t0;
    resetb = 1'b0;
    rxd    = 1'b1;
    idle(3);
    chk("reset_txd", txd, 1);
    chk("reset_gpio", gpio_o, 8'h00);
    chk("reset_led", led, 0);
    resetb  = 1'b1;
    rel_cyc = cyc;
    idle(7);
    chk("led_after_7", led, 0);
    idle(1);
`ifdef MB_MCS_HEARTBEAT_EN
    chk("led_after_8", led, 1);
`else
    chk("led_after_8", led, 0);
`endif
    idle(300);

    // Break: line held low, then released.
    rxd = 1'b0;
    idle(5000);
    rxd = 1'b1;
    idle(600);
    chk("break_no_tx", n_tx, 0);
    chk("break_gpio", gpio_o, 8'h00);

    // Short low glitch: start bit fails its mid-bit check.
    rxd = 1'b0;
    idle(50);
    rxd = 1'b1;
    idle(600);
    chk("glitch_no_tx", n_tx, 0);

    send_byte(8'h57, t0);
    send_byte(8'h3C, t0);
    chk("gpio_W3C", gpio_o, 8'h3C);
    idle(3000);
    chk("K_byte", last_tx_byte, 8'h4B);
    chk("K_latency", last_tx_start - t0, 2646);

    send_byte(8'h52, t0);
    idle(3000);
    chk("R_byte", last_tx_byte, 8'h96);
    chk("R_latency", last_tx_start - t0, 2646);

    send_byte(8'h00, t0);
    send_byte(8'h53, t0);
    idle(6000);
    chk("unknown_byte", prev_tx_byte, 8'h3F);
    chk("S_byte", last_tx_byte, 8'hA5);
    chk("tx_count", n_tx, 4);

    // Reset pulse in the middle of the 'K' frame that follows W,FF.
    send_byte(8'h57, t0);
    send_byte(8'hFF, t0);
    chk("gpio_WFF", gpio_o, 8'hFF);
    idle(1200);
    resetb = 1'b0;
    expq.delete();
    arg_pend   = 1'b0;
    gpio_cur   = 8'h00;
    gpio_at    = -1;
    last_start = -100000;
    #1;
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_gpio", gpio_o, 8'h00);
    idle(3);
    resetb  = 1'b1;
    rel_cyc = cyc;
    idle(300);

    send_byte(8'h57, t0);
    send_byte(8'h01, t0);
    chk("gpio_W01", gpio_o, 8'h01);
`ifndef MB_MCS_HEARTBEAT_EN
    chk("led_W01", led, 1);
`endif
    idle(3000);
    chk("K2_byte", last_tx_byte, 8'h4B);

    send_byte(8'h53, t0);
    idle(3000);
    chk("S2_byte", last_tx_byte, 8'hA5);
    chk("S2_latency", last_tx_start - t0, 2646);
    chk("responses_outstanding", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mb_mcs_io_top.md
# mb_mcs_io_top

Top-level I/O controller for the Papilio board. It runs from the 32 MHz board clock and exposes a UART command port (8N1) that lets a host drive an 8-bit general-purpose output, read an 8-bit general-purpose input, and get a status response. A free-running heartbeat drives the board LED. It takes the place of a MicroBlaze MCS system as the board's top level, with a fixed hardware command engine instead of firmware.

## Interface
Parameters:
- CLK_HZ, 32000000, input clock frequency.
- BAUD, 115200, UART bit rate; bit period = round(CLK_HZ/BAUD) = 278 cycles.
- LED_DIV_BITS, 24, heartbeat counter width; LED toggles every 2^(LED_DIV_BITS-1) cycles.

Ports:
- clk  in  1  system clock, 32 MHz, rising edge.
- resetb  in  1  asynchronous, active-low reset; one clock; all flops clear on resetb=0.
- rxd  in  1  UART receive, idle high.
- txd  out  1  UART transmit, idle high.
- led  out  1  heartbeat / status LED.
- gpio_o  out  8  general-purpose output register.
- gpio_i  in  8  general-purpose input.

## Operation
- Reset values: txd=1, led=0, gpio_o=8'h00, receiver/FSM idle, no pending response.
- rxd and gpio_i are each passed through a 2-flop synchronizer before use.
- Receiver:
  - A high-to-low edge on the synchronized rxd, seen while armed, starts a frame.
  - The start bit is re-checked at mid-bit (139 cycles); if it reads high, the frame is abandoned.
  - 8 data bits are sampled LSB first at bit centres, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the receiver disarms until rxd has been high for one full bit period. A line held low (break) therefore produces no bytes and no responses.
- Command FSM states: IDLE, ARG, RESP.
  - IDLE, byte 'W' (8'h57) -> ARG.
  - IDLE, byte 'R' (8'h52) -> queue response = synchronized gpio_i, sampled in the cycle the byte completes.
  - IDLE, byte 'S' (8'h53) -> queue response 8'hA5 (ID/status).
  - IDLE, any other byte -> queue '?' (8'h3F).
  - ARG, next byte -> gpio_o <= byte (updates the cycle after the byte completes), queue 'K' (8'h4B), return to IDLE.
- Response path: one-byte pending register. The transmitter loads it whenever the transmitter is idle. If a new response is queued while one is still pending, the new response overwrites the pending one (last wins).
- Transmitter frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit held 278 cycles.
- led = heartbeat counter MSB (see Configuration).

## Timing
- Byte-complete strobe: asserted one cycle after the stop-bit mid-sample.
- Response start (txd falls): 2 cycles after the byte-complete strobe when the transmitter is idle.
- TX frame length: 2780 cycles.
- gpio_o latency: 1 cycle after the byte-complete strobe of the argument byte.
- Reset asserted mid-frame aborts RX and TX immediately. txd returns high, the FSM returns to IDLE, and gpio_o clears.
- A falling rxd edge during a TX frame is accepted; RX and TX are full duplex.

## Configuration
- MB_MCS_HEARTBEAT_EN defined: a LED_DIV_BITS-bit counter increments every cycle; led = counter[LED_DIV_BITS-1]. The first led rise occurs 2^(LED_DIV_BITS-1) cycles after reset release.
- MB_MCS_HEARTBEAT_EN undefined: no counter is built; led = gpio_o[0].

## Test plan
- Reset, then hold rxd=0 for 100000 cycles -> txd stays 1, gpio_o=8'h00, no responses (break/framing-error path); led=0 throughout.
- rxd idle high, send 'W' then 8'h3C -> gpio_o=8'h3C one cycle after the second stop-bit sample; txd sends 8'h4B.
- gpio_i=8'h96, send 'R' -> txd frame carries 8'h96, with start bit 2 cycles after the byte-complete strobe.
- Send 8'h00 and then 'S' -> responses 8'h3F then 8'hA5, in order, each 2780 cycles long.
- Pulse resetb low mid-way through a TX frame after setting gpio_o=8'hFF -> txd=1 and gpio_o=8'h00 immediately; the next command works normally.
- With LED_DIV_BITS=4 and MB_MCS_HEARTBEAT_EN defined -> led toggles every 8 cycles. With the macro undefined, after 'W',8'h01 -> led=1.
